// File: rtl/fp16_add_norm_round.sv
// Half-precision adder back end: mantissa add/subtract, normalise, round-to-nearest-even, pack.
// Three register stages share one stall signal driven by the output handshake.
module fp16_add_norm_round #(
    parameter int FLUSH_SUBNORM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic        operation_in,
    input  logic [4:0]  big_exponent,
    input  logic [10:0] big_mantissa,
    input  logic [13:0] aligned_mantissa,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    always_ff @(posedge clk) begin
        assert (FLUSH_SUBNORM == 1) else $error("FLUSH_SUBNORM=0 is not supported");
    end

    logic adv;
    logic out_valid_reg;
    logic [15:0] result_reg;
    logic overflow_reg, underflow_reg, inexact_reg;

    assign adv       = ~out_valid_reg | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
    assign inexact   = inexact_reg;

    // Stage 1: add/subtract magnitudes at full 15-bit width
    logic [14:0] op_a, op_b, sum_next;
    logic        s1_valid_reg, s1_sign_reg, s1_special_reg;
    logic [4:0]  s1_exp_reg;
    logic [9:0]  s1_payload_reg;
    logic [14:0] s1_sum_reg;

    assign op_a     = {1'b0, big_mantissa, 3'b000};
    assign op_b     = {1'b0, aligned_mantissa};
    assign sum_next = operation_in ? (op_a - op_b) : (op_a + op_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_sign_reg    <= 1'b0;
            s1_special_reg <= 1'b0;
            s1_exp_reg     <= '0;
            s1_payload_reg <= '0;
            s1_sum_reg     <= '0;
        end else if (adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_sign_reg    <= sign_in;
                s1_special_reg <= (big_exponent == 5'd31);
                s1_exp_reg     <= big_exponent;
                s1_payload_reg <= big_mantissa[9:0];
                s1_sum_reg     <= sum_next;
            end
        end
    end

    // Stage 2: normalise so the leading one lands at m[13]
    logic [3:0]         lz;
    logic [13:0]        norm_m;
    logic signed [6:0]  norm_e;
    logic               s2_valid_reg, s2_sign_reg, s2_special_reg;
    logic [9:0]         s2_payload_reg;
    logic [13:0]        s2_m_reg;
    logic signed [6:0]  s2_e_reg;

    always_comb begin
        lz = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (s1_sum_reg[i]) lz = 4'(13 - i);
        end
        if (s1_sum_reg[14]) begin
            norm_m = {s1_sum_reg[14:2], s1_sum_reg[1] | s1_sum_reg[0]};
            norm_e = $signed({2'b00, s1_exp_reg}) + 7'sd1;
        end else begin
            norm_m = s1_sum_reg[13:0] << lz;
            norm_e = $signed({2'b00, s1_exp_reg}) - $signed({3'b000, lz});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg   <= 1'b0;
            s2_sign_reg    <= 1'b0;
            s2_special_reg <= 1'b0;
            s2_payload_reg <= '0;
            s2_m_reg       <= '0;
            s2_e_reg       <= '0;
        end else if (adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_sign_reg    <= s1_sign_reg;
                s2_special_reg <= s1_special_reg;
                s2_payload_reg <= s1_payload_reg;
                s2_m_reg       <= norm_m;
                s2_e_reg       <= norm_e;
            end
        end
    end

    // Stage 3: round to nearest even and pack; a clear m[13] after normalising means the sum was zero
    logic               g_bit, r_bit, s_bit, round_up;
    logic [10:0]        frac_sum;
    logic signed [6:0]  e_rnd;
    logic [15:0]        result_next;
    logic               overflow_next, underflow_next, inexact_next;

    always_comb begin
        g_bit    = s2_m_reg[2];
        r_bit    = s2_m_reg[1];
        s_bit    = s2_m_reg[0];
        round_up = g_bit & (r_bit | s_bit | s2_m_reg[3]);
        frac_sum = {1'b0, s2_m_reg[12:3]} + {10'd0, round_up};
        e_rnd    = frac_sum[10] ? (s2_e_reg + 7'sd1) : s2_e_reg;

        result_next    = {s2_sign_reg, e_rnd[4:0], frac_sum[9:0]};
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        inexact_next   = g_bit | r_bit | s_bit;

        if (s2_special_reg) begin
            result_next  = {s2_sign_reg, 5'h1F, s2_payload_reg};
            inexact_next = 1'b0;
        end else if (!s2_m_reg[13]) begin
            result_next  = 16'h0000;
            inexact_next = 1'b0;
        end else if (e_rnd >= 7'sd31) begin
            result_next   = {s2_sign_reg, 5'h1F, 10'd0};
            overflow_next = 1'b1;
            inexact_next  = 1'b1;
        end else if (e_rnd <= 7'sd0) begin
            result_next    = {s2_sign_reg, 15'd0};
            underflow_next = 1'b1;
            inexact_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            inexact_reg   <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                result_reg    <= result_next;
                overflow_reg  <= overflow_next;
                underflow_reg <= underflow_next;
                inexact_reg   <= inexact_next;
            end
        end
    end

endmodule

// File: tb/tb_fp16_add_norm_round.sv
// Bench for fp16_add_norm_round: integer RNE reference model, scoreboard queue, directed vectors,
// backpressure and mid-stream reset scenarios.
module tb_fp16_add_norm_round;

    logic        clk, rst, in_valid, in_ready, sign_in, operation_in;
    logic        out_valid, out_ready, overflow, underflow, inexact;
    logic [4:0]  big_exponent;
    logic [10:0] big_mantissa;
    logic [13:0] aligned_mantissa;
    logic [15:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit lat_en   = 1'b1;

    typedef struct {
        logic        s;
        logic        op;
        logic [4:0]  e;
        logic [10:0] bm;
        logic [13:0] al;
        logic [18:0] lit;   // {overflow, underflow, inexact, result}
    } vec_t;

    typedef struct {
        logic [18:0] expv;
        int          c;
        bit          lat;
    } exp_t;

    vec_t vecs[16];
    exp_t exp_q[$];

    fp16_add_norm_round #(.FLUSH_SUBNORM(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .operation_in(operation_in),
        .big_exponent(big_exponent), .big_mantissa(big_mantissa),
        .aligned_mantissa(aligned_mantissa),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .underflow(underflow), .inexact(inexact)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Exact-value reference: integer sum, round-to-nearest-even on an 11-bit significand.
    function automatic logic [18:0] model(input logic s, input logic op, input logic [4:0] ex,
                                          input logic [10:0] bm, input logic [13:0] al);
        int a, b, sum, p, e, sh, q, rem, half;
        bit inx;
        logic [4:0] e5;
        logic [9:0] f10;
        a   = int'(bm) * 8;
        b   = int'(al);
        sum = op ? (a - b) : (a + b);
        if (ex == 5'd31) return {3'b000, s, 5'h1F, bm[9:0]};
        if (sum == 0) return 19'd0;
        p = 0;
        for (int i = 0; i < 15; i++) if (((sum >> i) & 1) == 1) p = i;
        e   = int'(ex) + p - 13;
        inx = 1'b0;
        if (p >= 10) begin
            sh  = p - 10;
            q   = sum >> sh;
            rem = sum - (q << sh);
            if (sh > 0) begin
                half = 1 << (sh - 1);
                if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
            end
            inx = (rem != 0);
        end else begin
            q = sum << (10 - p);
        end
        if (q == 2048) begin
            q = 1024;
            e = e + 1;
        end
        if (e >= 31) return {3'b101, s, 5'h1F, 10'd0};
        if (e <= 0)  return {3'b011, s, 15'd0};
        e5  = e[4:0];
        f10 = q[9:0];
        return {2'b00, inx, s, e5, f10};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic apply(input int idx);
        sign_in          = vecs[idx].s;
        operation_in     = vecs[idx].op;
        big_exponent     = vecs[idx].e;
        big_mantissa     = vecs[idx].bm;
        aligned_mantissa = vecs[idx].al;
    endtask

    task automatic stream(input int first, input int n);
        int k = 0;
        int guard = 0;
        bit acc;
        while (k < n && guard < 100) begin
            apply(first + k);
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            guard++;
        end
        in_valid = 1'b0;
        check("stream_accept", 32'(k), 32'(n));
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Compare process: scoreboard, latency and hold-stability checks on every negedge.
    initial begin : monitor
        exp_t ent;
        logic [18:0] act, held_val;
        bit held;
        int ntx;
        held = 1'b0;
        ntx  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                held = 1'b0;
            end else begin
                act = {overflow, underflow, inexact, result};
                if (held) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    if (out_valid) check("hold_stable", 32'(act), 32'(held_val));
                end
                held     = out_valid && !out_ready;
                held_val = act;
                if (in_valid && in_ready) begin
                    ent.expv = model(sign_in, operation_in, big_exponent, big_mantissa, aligned_mantissa);
                    ent.c    = cyc;
                    ent.lat  = lat_en;
                    exp_q.push_back(ent);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", 32'(act), 32'hFFFF_FFFF);
                    end else begin
                        ent = exp_q.pop_front();
                        check("result_flags", 32'(act), 32'(ent.expv));
                        if (ent.lat) check("latency", 32'(cyc - ent.c), 32'd3);
                        $display("txn %0d: result=%h ovf=%0b unf=%0b inx=%0b expected=%h", ntx, result,
                                 overflow, underflow, inexact, ent.expv);
                        ntx++;
                    end
                end
            end
        end
    end

    initial begin : main
        vecs[0]  = '{1'b0, 1'b0, 5'd15, 11'h400, 14'h2000, {3'b000, 16'h4000}};
        vecs[1]  = '{1'b1, 1'b1, 5'd15, 11'h400, 14'h2000, {3'b000, 16'h0000}};
        vecs[2]  = '{1'b0, 1'b0, 5'd15, 11'h400, 14'h0004, {3'b001, 16'h3C00}};
        vecs[3]  = '{1'b0, 1'b0, 5'd15, 11'h401, 14'h0004, {3'b001, 16'h3C02}};
        vecs[4]  = '{1'b0, 1'b0, 5'd30, 11'h7FF, 14'h3FF8, {3'b101, 16'h7C00}};
        vecs[5]  = '{1'b0, 1'b1, 5'd1,  11'h400, 14'h1FF8, {3'b011, 16'h0000}};
        vecs[6]  = '{1'b1, 1'b0, 5'd31, 11'h600, 14'h0123, {3'b000, 16'hFE00}};
        vecs[7]  = '{1'b0, 1'b0, 5'd15, 11'h7FF, 14'h0007, {3'b001, 16'h4000}};
        vecs[8]  = '{1'b1, 1'b1, 5'd10, 11'h400, 14'h0008, {3'b000, 16'hA7FE}};
        vecs[9]  = '{1'b0, 1'b0, 5'd20, 11'h400, 14'h2008, {3'b001, 16'h5400}};
        vecs[10] = '{1'b0, 1'b0, 5'd20, 11'h400, 14'h200A, {3'b001, 16'h5401}};
        vecs[11] = '{1'b0, 1'b0, 5'd30, 11'h7FF, 14'h0004, {3'b101, 16'h7C00}};
        vecs[12] = '{1'b0, 1'b1, 5'd2,  11'h400, 14'h0008, {3'b000, 16'h07FE}};
        vecs[13] = '{1'b0, 1'b1, 5'd1,  11'h400, 14'h0008, {3'b011, 16'h0000}};
        vecs[14] = '{1'b1, 1'b1, 5'd1,  11'h400, 14'h0008, {3'b011, 16'h8000}};
        vecs[15] = '{1'b0, 1'b1, 5'd15, 11'h400, 14'h1FFF, {3'b000, 16'h0800}};

        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        apply(0);
        #2 rst = 1'b1;
        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs", 32'({overflow, underflow, inexact, result}), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++)
            check("model_pin", 32'(model(vecs[i].s, vecs[i].op, vecs[i].e, vecs[i].bm, vecs[i].al)),
                  32'(vecs[i].lit));

        for (int i = 0; i < 16; i++) begin
            stream(i, 1);
            drain();
        end

        stream(0, 16);
        drain();

        // Backpressure: five bundles offered, only three fit while the output is stalled
        begin
            int k = 0;
            bit acc;
            out_ready = 1'b0;
            lat_en    = 1'b0;
            for (int c = 0; c < 8; c++) begin
                if (k < 5) begin
                    apply(k);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                if (acc) k++;
            end
            in_valid = 1'b0;
            check("stall_accepted", 32'(k), 32'd3);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            out_ready = 1'b1;
            stream(3, 2);
            drain();
        end

        // Reset while a stalled result is being presented
        out_ready = 1'b0;
        stream(5, 3);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'({overflow, underflow, inexact, result}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        lat_en    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end

        stream(0, 16);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
